// File: rtl/regwrite_arbiter.sv
// Register-file write arbiter: three requesters share one write port; the winner gets a one-cycle grant slot.
// Latency: 1 cycle from sampled req to gnt/wr_en/wr_addr/wr_data; all outputs registered.
// Backpressure: after each grant the block is busy for one cycle (max one write per 2 cycles); losers stay pending and withdrawn requests are dropped.
// Build option: define REGWRITE_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default fixed priority 0 > 1 > 2).
module regwrite_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [4:0]  addr0,
    input  logic [4:0]  addr1,
    input  logic [4:0]  addr2,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  gnt,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    // One-hot winner among the current requests (zero when nobody requests)
    logic [2:0]  win;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

`ifdef REGWRITE_ARBITER_ROUND_ROBIN_EN
    // Rotation pointer: requester with highest priority on the next arbitration
    logic [1:0] ptr_q, ptr_d;

    // Round-robin pick: scan p, p+1, p+2 (mod 3) and take the first requester
    always_comb begin
        win = 3'b000;
        case (ptr_q)
            2'd1: begin
                if (req[1])      win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd2: begin
                if (req[2])      win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if (req[0])      win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end

    // Pointer moves to the requester just after the winner, only when a grant is issued
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && req != 3'b000) begin
            if (win[0])      ptr_d = 2'd1;
            else if (win[1]) ptr_d = 2'd2;
            else             ptr_d = 2'd0;
        end
    end

    // Pointer register, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: requester 0 beats 1 beats 2; no pointer state
    always_comb begin
        win    = 3'b000;
        win[0] = req[0];
        win[1] = req[1] & ~req[0];
        win[2] = req[2] & ~req[1] & ~req[0];
    end
`endif

    // Steer the winner's address and data toward the write port registers
    always_comb begin
        sel_addr = addr0;
        sel_data = data0;
        if (win[1]) begin
            sel_addr = addr1;
            sel_data = data1;
        end else if (win[2]) begin
            sel_addr = addr2;
            sel_data = data2;
        end
    end

    // Next-state and registered-output values; GRANT always lasts one cycle
    always_comb begin
        state_d   = state_q;
        gnt_d     = 3'b000;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d   = GRANT;
                    gnt_d     = win;
                    // Register 0 is hard-wired: the grant is honoured but nothing is written
                    wr_en_d   = (sel_addr != 5'd0);
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= 3'b000;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == GRANT);

endmodule
